// File: rtl/fetch_queue_pkg.sv
// Shared pipeline types for the fetch/decode boundary.
// Holds the bubble encoding, queue state and entry bundle.
package fetch_queue_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] BUBBLE_IR = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN,
        BUBBLE
    } fq_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic [XLEN-1:0] ir;
    } if_entry_t;

    // What the decode-facing register loads on a given edge.
    typedef enum logic [2:0] {
        SEL_FLUSH,
        SEL_HAZARD,
        SEL_HOLD,
        SEL_HEAD,
        SEL_BYPASS,
        SEL_IDLE
    } out_sel_t;

    function automatic logic is_bubble(input logic [XLEN-1:0] ir);
        return ir == BUBBLE_IR;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue.
// One synchronous write port, one asynchronous read port.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int DW    = 96,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer with hazard bubbles
// and taken-branch flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int BUBBLE_CYCLES = 2,
    parameter int W             = XLEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_pc,
    input  logic [W-1:0]           in_npc,
    input  logic [W-1:0]           in_ir,
    input  logic                   hazard_req,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [W-1:0]           out_pc,
    output logic [W-1:0]           out_npc,
    output logic [W-1:0]           out_ir,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BUBBLE_CYCLES + 1);
    localparam int DW = $bits(if_entry_t);

    localparam logic [BW-1:0] BUB_LOAD = BW'(BUBBLE_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [BW-1:0] bub_cnt;
    fq_state_t     state;
    out_sel_t      sel;

    logic      enq;
    logic      adv;
    logic      push;
    logic      pop;
    logic      empty;
    if_entry_t wentry;
    if_entry_t head;

    assign in_ready = (count < FULL_CNT) && !flush;
    assign enq      = in_valid && in_ready;
    assign adv      = (state == RUN) && !hazard_req && !flush;
    assign empty    = (count == '0);

    assign wentry.pc  = in_pc;
    assign wentry.npc = in_npc;
    assign wentry.ir  = in_ir;

    // Terms are mutually exclusive and cover every case.
    always_comb begin
        sel = SEL_IDLE;
        unique case (1'b1)
            flush:
                sel = SEL_FLUSH;
            !flush && hazard_req:
                sel = SEL_HAZARD;
            !flush && !hazard_req && state == BUBBLE:
                sel = SEL_HOLD;
            adv && !empty:
                sel = SEL_HEAD;
            adv && empty && enq:
                sel = SEL_BYPASS;
            adv && empty && !enq:
                sel = SEL_IDLE;
        endcase
    end

    assign push = enq && (sel != SEL_BYPASS);
    assign pop  = (sel == SEL_HEAD);

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wentry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            state     <= RUN;
            bub_cnt   <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_npc   <= '0;
            out_ir    <= W'(BUBBLE_IR);
        end else begin
            unique case (sel)
                SEL_FLUSH: begin
                    out_valid <= 1'b0;
                    out_ir    <= W'(BUBBLE_IR);
                    state     <= RUN;
                    bub_cnt   <= '0;
                end
                SEL_HAZARD: begin
                    out_valid <= 1'b0;
                    out_ir    <= W'(BUBBLE_IR);
                    state     <= (BUBBLE_CYCLES > 1) ? BUBBLE : RUN;
                    bub_cnt   <= BUB_LOAD;
                end
                // bub_cnt counts bubbles still owed, this edge included.
                SEL_HOLD: begin
                    out_valid <= 1'b0;
                    out_ir    <= W'(BUBBLE_IR);
                    if (bub_cnt <= BW'(1)) begin
                        state   <= RUN;
                        bub_cnt <= '0;
                    end else begin
                        bub_cnt <= bub_cnt - 1'b1;
                    end
                end
                SEL_HEAD: begin
                    out_valid <= 1'b1;
                    out_pc    <= head.pc;
                    out_npc   <= head.npc;
                    out_ir    <= head.ir;
                end
                SEL_BYPASS: begin
                    out_valid <= 1'b1;
                    out_pc    <= in_pc;
                    out_npc   <= in_npc;
                    out_ir    <= in_ir;
                end
                default: begin
                    out_valid <= 1'b0;
                    out_ir    <= W'(BUBBLE_IR);
                end
            endcase

            if (sel == SEL_FLUSH) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a
// queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int BC    = 2;
    localparam int W     = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_pc = '0;
    logic [W-1:0] in_npc = '0;
    logic [W-1:0] in_ir = '0;
    logic         hazard_req = 1'b0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_pc;
    logic [W-1:0] out_npc;
    logic [W-1:0] out_ir;
    logic [2:0]   count;

    fetch_queue #(
        .DEPTH         (DEPTH),
        .BUBBLE_CYCLES (BC),
        .W             (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_npc     (in_npc),
        .in_ir      (in_ir),
        .hazard_req (hazard_req),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_npc    (out_npc),
        .out_ir     (out_ir),
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queued entries plus bubbles still owed.
    if_entry_t   m_q[$];
    int          m_bub = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_npc = '0;
    logic [31:0] m_ir = 32'hFFFF_FFFF;
    bit          acc;

    task automatic model_reset();
        m_q.delete();
        m_bub   = 0;
        m_valid = 1'b0;
        m_pc    = '0;
        m_npc   = '0;
        m_ir    = 32'hFFFF_FFFF;
    endtask

    task automatic model_bubble();
        m_valid = 1'b0;
        m_ir    = 32'hFFFF_FFFF;
    endtask

    task automatic model_edge();
        if_entry_t e;
        if_entry_t n;
        n.pc  = in_pc;
        n.npc = in_npc;
        n.ir  = in_ir;
        if (flush) begin
            m_q.delete();
            m_bub = 0;
            model_bubble();
        end else if (hazard_req) begin
            model_bubble();
            m_bub = BC - 1;
            if (acc) m_q.push_back(n);
        end else if (m_bub > 0) begin
            model_bubble();
            m_bub--;
            if (acc) m_q.push_back(n);
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_valid = 1'b1;
            m_pc    = e.pc;
            m_npc   = e.npc;
            m_ir    = e.ir;
            if (acc) m_q.push_back(n);
        end else if (acc) begin
            m_valid = 1'b1;
            m_pc    = n.pc;
            m_npc   = n.npc;
            m_ir    = n.ir;
        end else begin
            model_bubble();
        end
    endtask

    task automatic check_out(input string where);
        check({where, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({where, ".out_ir"}, out_ir, m_ir);
        check({where, ".out_pc"}, out_pc, m_pc);
        check({where, ".out_npc"}, out_npc, m_npc);
        check({where, ".count"}, 32'(count), 32'(m_q.size()));
    endtask

    task automatic step(input bit v, input logic [31:0] ir,
                        input bit haz, input bit fl);
        logic exp_rdy;
        @(negedge clk);
        in_valid   = v;
        in_ir      = ir;
        in_pc      = {ir[29:0], 2'b00} ^ 32'h0001_0000;
        in_npc     = in_pc + 32'd4;
        hazard_req = haz;
        flush      = fl;
        #1;
        exp_rdy = (m_q.size() < DEPTH) && !fl;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_out("edge");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.in_ready", 32'(in_ready), 32'd1);

        // Back-to-back streaming through the bypass path.
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        idle(2);

        // Three queued entries, then an isolated hazard pulse.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h10 + 32'(i), 1'b1, 1'b0);
        check("hazard.queued", 32'(count), 32'd3);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        idle(5);

        // Fill to full under repeated hazards; fifth entry stalls.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h20 + 32'(i), 1'b1, 1'b0);
        check("full.count", 32'(count), 32'd4);
        begin
            int tries = 0;
            do begin
                step(1'b1, 32'h24, 1'b0, 1'b0);
                tries++;
            end while (!acc && tries < 20);
            check("full.retry_accepted", 32'(acc), 32'd1);
        end
        idle(7);

        // Flush with a simultaneous offer.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + 32'(i), 1'b1, 1'b0);
        step(1'b1, 32'hAAAA_0000, 1'b0, 1'b1);
        check("flush.count", 32'(count), 32'd0);
        step(1'b1, 32'hBBBB_0000, 1'b0, 1'b0);
        check("flush.bypass", out_ir, 32'hBBBB_0000);
        idle(2);

        // Flush one edge into a bubble run.
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h40, 1'b0, 1'b0);
        check("flushbub.bypass", out_ir, 32'h40);
        idle(2);

        // Asynchronous reset between edges with two queued.
        step(1'b1, 32'h50, 1'b1, 1'b0);
        step(1'b1, 32'h51, 1'b1, 1'b0);
        @(negedge clk);
        in_valid   = 1'b0;
        hazard_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_out("async_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_rst.in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom,
                 ($urandom % 8) == 0, ($urandom % 16) == 0);
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
